// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: op encoding and default geometry shared by pipe_adder and its bench
package pipe_adder_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_STAGES = 4;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/adder_slice.sv
// adder_slice: SEG-bit combinational adder segment with carry in and carry out
module adder_slice #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_ci,
  output logic [SEG-1:0] o_s,
  output logic           o_co
);
  assign {o_co, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{SEG{1'b0}}, i_ci};
endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: STAGES-deep segmented add/sub pipeline with valid/ready flow control
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output out_ovf.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             out_ovf
`endif
);
  localparam int SEG = WIDTH / STAGES;
  localparam int L = STAGES - 1;

  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_v;

  logic [WIDTH-1:0]  w_a_in [STAGES];
  logic [WIDTH-1:0]  w_b_in [STAGES];
  logic [WIDTH-1:0]  w_s_in [STAGES];
  logic [WIDTH-1:0]  w_s_nx [STAGES];
  logic [SEG-1:0]    w_seg  [STAGES];
  logic [STAGES-1:0] w_c_in;
  logic [STAGES-1:0] w_v_in;
  logic [STAGES-1:0] w_co;
  logic              w_adv;

  assign w_adv     = !r_v[L] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v[L];
  assign out_sum   = r_s[L];
  assign out_carry = r_c[L];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_a_in[k] = in_a;
      assign w_b_in[k] = (in_op == OP_SUB) ? ~in_b : in_b;
      assign w_s_in[k] = '0;
      assign w_c_in[k] = (in_op == OP_SUB);
      assign w_v_in[k] = in_valid;
    end else begin : g_link
      assign w_a_in[k] = r_a[k-1];
      assign w_b_in[k] = r_b[k-1];
      assign w_s_in[k] = r_s[k-1];
      assign w_c_in[k] = r_c[k-1];
      assign w_v_in[k] = r_v[k-1];
    end
    adder_slice #(.SEG(SEG)) u_slice (
      .i_a  (w_a_in[k][k*SEG +: SEG]),
      .i_b  (w_b_in[k][k*SEG +: SEG]),
      .i_ci (w_c_in[k]),
      .o_s  (w_seg[k]),
      .o_co (w_co[k])
    );
    assign w_s_nx[k] = (w_s_in[k] & ~(WIDTH'({SEG{1'b1}}) << (k*SEG))) | (WIDTH'(w_seg[k]) << (k*SEG));
  end

  // the whole pipe shifts together on advance; a stall freezes every stage, holding the output
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
        r_s[i] <= '0;
      end
      r_c <= '0;
      r_v <= '0;
    end else if (w_adv) begin
      for (int i = 0; i < STAGES; i++) begin
        r_a[i] <= w_a_in[i];
        r_b[i] <= w_b_in[i];
        r_s[i] <= w_s_nx[i];
      end
      r_c <= w_co;
      r_v <= w_v_in;
    end

`ifdef PIPE_ADDER_OVF_EN
  logic r_ovf;
  logic w_ovf_nx;
  assign w_ovf_nx = w_co[L] ^ w_a_in[L][WIDTH-1] ^ w_b_in[L][WIDTH-1] ^ w_seg[L][SEG-1];
  assign out_ovf  = r_ovf;
  // overflow = carry into MSB (recovered as a^b^s at the MSB) xor carry out, kept with its beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ovf <= 1'b0;
    else if (w_adv) r_ovf <= w_ovf_nx;
`endif
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: vector table, scoreboard and random traffic for pipe_adder (32 bits, 4 stages)
module tb_pipe_adder;
  import pipe_adder_pkg::*;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_carry;
`ifdef PIPE_ADDER_OVF_EN
  logic        out_ovf;
`endif

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   out_cnt = 0;
  int   out_cyc [1024];
  exp_t q [$];
  exp_t cur_exp;
  logic hold_v = 1'b0;
  logic [31:0] hold_s;
  logic hold_c;
  logic done;
  vec_t tbl [9];

  pipe_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry)
`ifdef PIPE_ADDER_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic [31:0] bb;
    logic [32:0] r;
    exp_t e;
    bb = op ? ~b : b;
    r = {1'b0, a} + {1'b0, bb} + {32'd0, op};
    e.s = r[31:0];
    e.c = r[32];
    e.o = (a[31] == bb[31]) && (r[31] != a[31]);
    return e;
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic op,
                              input logic [31:0] s, input logic c, input logic o);
    vec_t v;
    v.a = a;
    v.b = b;
    v.op = op;
    v.e.s = s;
    v.e.c = c;
    v.e.o = o;
    return v;
  endfunction

  // monitor: scoreboard push on accept, pop/compare on emit, hold check while stalled
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) hold_v = 1'b0;
    else begin
      if (hold_v && out_valid) begin
        chk("hold_sum", out_sum, hold_s);
        chk("hold_carry", out_carry, hold_c);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", q.size(), 1);
        else begin
          e = q.pop_front();
          chk("sum", out_sum, e.s);
          chk("carry", out_carry, e.c);
`ifdef PIPE_ADDER_OVF_EN
          chk("ovf", out_ovf, e.o);
`endif
        end
        if (out_cnt < 1024) out_cyc[out_cnt] = cyc;
        out_cnt++;
      end
      if (in_valid && in_ready) q.push_back(cur_exp);
      hold_v = out_valid && !out_ready;
      hold_s = out_sum;
      hold_c = out_carry;
    end
  end

  // called at posedge+1; returns at posedge+1 after the accepting edge, in_valid left high
  task automatic drive(input vec_t v);
    int n;
    in_a = v.a;
    in_b = v.b;
    in_op = v.op;
    cur_exp = v.e;
    in_valid = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
    end
    if (n == 100) chk("accept_timeout", n, 0);
  endtask

  task automatic lat_check(input string nm);
    int n;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk(nm, n, 4);
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && q.size() > 0; i++) @(negedge clk);
    chk("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    tbl[0] = mk(32'h0000_0001, 32'hFFFF_FFFF, OP_ADD, 32'h0000_0000, 1'b1, 1'b0);
    tbl[1] = mk(32'h8000_0000, 32'h0000_0001, OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1);
    tbl[2] = mk(32'h0000_0000, 32'h0000_0001, OP_SUB, 32'hFFFF_FFFF, 1'b0, 1'b0);
    tbl[3] = mk(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 32'h8000_0000, 1'b0, 1'b1);
    tbl[4] = mk(32'h1234_5678, 32'h8765_4321, OP_ADD, 32'h9999_9999, 1'b0, 1'b0);
    tbl[5] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_ADD, 32'hFFFF_FFFE, 1'b1, 1'b0);
    tbl[6] = mk(32'h0000_0005, 32'h0000_0005, OP_SUB, 32'h0000_0000, 1'b1, 1'b0);
    tbl[7] = mk(32'h0000_FFFF, 32'h0000_0001, OP_ADD, 32'h0001_0000, 1'b0, 1'b0);
    tbl[8] = mk(32'h8000_0000, 32'h8000_0000, OP_ADD, 32'h0000_0000, 1'b1, 1'b1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_op = OP_ADD;
    out_ready = 1'b1;
    done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_carry", out_carry, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // single beat: full carry ripple and exact latency
    drive(tbl[0]);
    in_valid = 1'b0;
    lat_check("latency_first");
    drain();
    // whole table back to back
    for (int i = 0; i < 9; i++) drive(tbl[i]);
    in_valid = 1'b0;
    drain();
    // ten beats back to back must emerge on consecutive cycles
    c0 = out_cnt;
    for (int i = 0; i < 10; i++) drive(mk(i, i << 24, OP_ADD, i + (i << 24), 1'b0, 1'b0));
    in_valid = 1'b0;
    drain();
    chk("burst_count", out_cnt - c0, 10);
    chk("burst_span", out_cyc[c0 + 9] - out_cyc[c0], 9);
    // fill the pipe, stall the output for three cycles, then release
    for (int i = 0; i < 4; i++) drive(mk(32'h0101_0101 * (i + 1), 32'h00FF_00FF, OP_SUB,
                                         model(32'h0101_0101 * (i + 1), 32'h00FF_00FF, OP_SUB).s,
                                         model(32'h0101_0101 * (i + 1), 32'h00FF_00FF, OP_SUB).c,
                                         model(32'h0101_0101 * (i + 1), 32'h00FF_00FF, OP_SUB).o));
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    // reset with beats in flight: output drops at once and the beats never emerge
    for (int i = 0; i < 3; i++) drive(mk(32'hA000_0000 + i, 32'h1, OP_ADD, 32'hA000_0001 + i, 1'b0, 1'b0));
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_out_sum", out_sum, 0);
    q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("flushed_out_valid", out_valid, 0);
    end
    @(posedge clk);
    #1;
    drive(mk(32'h0000_00FF, 32'h0000_0001, OP_ADD, 32'h0000_0100, 1'b0, 1'b0));
    in_valid = 1'b0;
    lat_check("latency_after_reset");
    drain();
    // random add/sub with random bubbles and random backpressure
    fork
      begin
        logic [31:0] a;
        logic [31:0] b;
        logic op;
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          a = $urandom;
          b = $urandom;
          op = 1'($urandom_range(1));
          if (i % 7 == 0) b = a;
          drive('{a: a, b: b, op: op, e: model(a, b, op)});
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    repeat (4) @(negedge clk);
    chk("final_out_valid", out_valid, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
